shift_pipe: RTL
===============

Name: shift_pipe

Overview:
- Parametrised, pipelined successor to the combinational imm5 shifter used in the MOV/data-processing path.
- Adds register-specified shift amounts (Rs[7:0]), RRX, and a carry-out for flag update.
- Adds a valid/ready handshake with a 2-stage pipeline so the shift can sit between the register-read and ALU stages without lengthening the critical path.

Parameters:
- WIDTH, 32, datapath width; power of two, 8..64. Let LW = log2(WIDTH).
- AMT_W, 8, width of the register-specified shift amount (ARM: Rs[7:0]); AMT_W > LW.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept the input beat
- in_data  in  WIDTH  operand (Rm)
- in_amt  in  AMT_W  shift amount; in imm mode only in_amt[LW-1:0] is used
- in_type  in  2  00 LSL | 01 LSR | 10 ASR | 11 ROR
- in_reg_mode  in  1  0 = immediate-amount rules, 1 = register-amount rules
- in_carry  in  1  current C flag (used for RRX and for zero register shifts)
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts the result beat
- out_data  out  WIDTH  shifted result
- out_carry  out  1  shifter carry-out

Behaviour:
- Reset: async on rst_n low. Stage-1 valid, stage-2 valid, out_valid, out_data and out_carry all clear to 0. in_ready = 1 once out of reset. Reset mid-operation discards every in-flight beat.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on a rising edge.
  - out_valid, out_data and out_carry must hold stable while out_valid=1 and out_ready=0.
  - adv2 = !v2 || out_ready. adv1 = !v1 || adv2. in_ready = adv1 (combinational from out_ready; no other comb path input->output).
  - Latency: exactly 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 beat/cycle. There are no bubbles when out_ready is held high.
- Stage 1 (normalise): registers the operand, type and carry, plus an effective amount n (0..2^AMT_W-1) and a mode code.
  - Imm mode, n = in_amt[LW-1:0]:
    - LSL #0 = pass, carry = in_carry.
    - LSR #0 means WIDTH.
    - ASR #0 means WIDTH.
    - ROR #0 means RRX.
  - Reg mode, n = in_amt (full AMT_W):
    - n==0 for any type = pass, carry = in_carry.
- Stage 2 (shift + carry), n ≥ 1 (d = in_data):
  - LSL:
    - n<WIDTH: d<<n, C=d[WIDTH-n].
    - n==WIDTH: 0, C=d[0].
    - n>WIDTH: 0, C=0.
  - LSR:
    - n<WIDTH: d>>n, C=d[n-1].
    - n==WIDTH: 0, C=d[WIDTH-1].
    - n>WIDTH: 0, C=0.
  - ASR:
    - n<WIDTH: arithmetic shift, C=d[n-1].
    - n≥WIDTH: all bits = d[WIDTH-1], C=d[WIDTH-1].
  - ROR, reg mode, m = n mod WIDTH:
    - m≠0: rotate right m, C=d[m-1].
    - m==0: d unchanged, C=d[WIDTH-1].
  - RRX: {in_carry, d[WIDTH-1:1]}, C=d[0].
- Shift result width is always WIDTH; no bits beyond WIDTH are produced. Amount arithmetic uses AMT_W+1 bits so n==WIDTH never aliases.
- Stalled stages hold all registered fields. Simultaneous input accept and output drain in one cycle is legal and must not drop or duplicate beats.
- in_type is fully decoded; no X is ever driven on out_data.

Test Plan:
- Imm mode, WIDTH=32, d=0x8000_0001:
  - LSL #1 -> 0x0000_0002, C=1.
  - LSR #0 -> 0x0000_0000, C=1.
  - ASR #0 -> 0xFFFF_FFFF, C=1.
  - ROR #0 with in_carry=1 -> 0xC000_0000, C=1.
- Reg mode, d=0x0000_00F1:
  - LSR n=0, in_carry=0 -> 0x0000_00F1, C=0.
  - LSL n=32 -> 0, C=1.
  - LSL n=33 -> 0, C=0.
  - ROR n=36 -> 0x1000_000F, C=0.
  - ROR n=64 -> 0x0000_00F1, C=0.
- Back-to-back: 8 beats with out_ready=1 -> first out_valid exactly 2 cycles after the first accept. Results arrive in order, one per cycle, and in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles while driving 4 beats -> in_ready falls after 2 accepted beats. out_data/out_carry stay stable. Release -> all beats delivered in order, none lost.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately (async). After release, out_valid stays 0 until a new beat is accepted + 2 cycles.
- Generalisation: WIDTH=16, imm ASR #0 on 0x8000 -> 0xFFFF, C=1. Reg mode LSR n=16 on 0x8001 -> 0x0000, C=1.

Source files
------------

// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter with ARM-style imm/reg amount rules, RRX and carry-out.
// Stage 1 normalises the amount into (n, mode); stage 2 shifts and registers the result.
module shift_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_type,
  input  logic             in_reg_mode,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int unsigned LW = $clog2(WIDTH);
  // One extra bit so an amount equal to WIDTH never aliases onto zero.
  localparam logic [AMT_W:0] NW = (AMT_W + 1)'(WIDTH);

  typedef enum logic [1:0] {ModePass, ModeShift, ModeRrx} mode_e;

  logic             v1_q, v2_q;
  logic [WIDTH-1:0] d1_q;
  logic [1:0]       type1_q;
  logic             c1_q;
  logic [AMT_W:0]   n1_q;
  mode_e            mode1_q;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;

  logic adv1, adv2;

  assign adv2      = !v2_q || out_ready;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign out_data  = data_q;
  assign out_carry = carry_q;

  // Stage 1: amount normalisation.
  logic [LW-1:0]  imm_amt;
  logic [AMT_W:0] n_norm;
  mode_e          mode_norm;

  always_comb begin
    imm_amt   = in_amt[LW-1:0];
    n_norm    = '0;
    mode_norm = ModeShift;
    if (in_reg_mode) begin
      n_norm = {1'b0, in_amt};
      if (in_amt == '0) mode_norm = ModePass;
    end else if (imm_amt == '0) begin
      case (in_type)
        2'b00:   mode_norm = ModePass;
        2'b11:   mode_norm = ModeRrx;
        default: n_norm    = NW;
      endcase
    end else begin
      n_norm = (AMT_W + 1)'(imm_amt);
    end
  end

  // Stage 2: shift and carry. Padding bits on each side capture the last bit shifted out.
  logic [LW-1:0]      n_lo;
  logic               n_lt, n_eq;
  logic [WIDTH:0]     lsl_w, lsr_w;
  logic signed [WIDTH:0] asr_w;
  logic [WIDTH-1:0]   ror_w;
  logic [WIDTH-1:0]   res;
  logic               res_c;

  always_comb begin
    n_lo  = n1_q[LW-1:0];
    n_lt  = n1_q < NW;
    n_eq  = n1_q == NW;
    lsl_w = {1'b0, d1_q} << n_lo;
    lsr_w = {d1_q, 1'b0} >> n_lo;
    asr_w = $signed({d1_q, 1'b0}) >>> n_lo;
    ror_w = WIDTH'({d1_q, d1_q} >> n_lo);
    res   = d1_q;
    res_c = c1_q;
    case (mode1_q)
      ModeRrx: begin
        res   = {c1_q, d1_q[WIDTH-1:1]};
        res_c = d1_q[0];
      end
      ModeShift: begin
        case (type1_q)
          2'b00: begin
            res   = n_lt ? lsl_w[WIDTH-1:0] : '0;
            res_c = n_lt ? lsl_w[WIDTH] : (n_eq & d1_q[0]);
          end
          2'b01: begin
            res   = n_lt ? lsr_w[WIDTH:1] : '0;
            res_c = n_lt ? lsr_w[0] : (n_eq & d1_q[WIDTH-1]);
          end
          2'b10: begin
            res   = n_lt ? asr_w[WIDTH:1] : {WIDTH{d1_q[WIDTH-1]}};
            res_c = n_lt ? asr_w[0] : d1_q[WIDTH-1];
          end
          default: begin
            res   = ror_w;
            res_c = ror_w[WIDTH-1];
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      d1_q    <= '0;
      type1_q <= '0;
      c1_q    <= 1'b0;
      n1_q    <= '0;
      mode1_q <= ModePass;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          d1_q    <= in_data;
          type1_q <= in_type;
          c1_q    <= in_carry;
          n1_q    <= n_norm;
          mode1_q <= mode_norm;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          data_q  <= res;
          carry_q <= res_c;
        end
      end
    end
  end

endmodule
